not_gate_arbiter: RTL and testbench

- Shares one parameterized bitwise-inversion datapath (not_gate) among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered result carries the winning requester's ID on a single response channel.
- Sits between several producers needing inverted words and one shared downstream consumer; sustains 1 result/cycle under no backpressure.

---
 rtl/not_gate_arb_pkg.sv | 15 +
 rtl/not_gate.sv | 11 +
 rtl/rr_arbiter.sv | 59 +++++
 rtl/not_gate_arbiter.sv | 92 +++++++++
 tb/tb_not_gate_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/not_gate_arb_pkg.sv
// Shared types and helpers for the not_gate_arbiter slice.
// Optional build macro: NOT_ARB_FIXED_PRIO_EN (fixed-priority grant instead of round-robin).
package not_gate_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Index width for n requesters; a single requester still needs a 1-bit ID.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/not_gate.sv
// Parameterized bitwise inverter shared by all requesters.
module not_gate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = ~i_a;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational grant: round-robin from PTR, or lowest index when NOT_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
    import not_gate_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] REQ_VALID,
    input  logic [ID_W-1:0]    PTR,
    output logic [NUM_REQ-1:0] GNT,
    output logic [ID_W-1:0]    GNT_IDX
);

`ifdef NOT_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^PTR;

    always_comb begin
        logic w_found;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        GNT     = '0;
        GNT_IDX = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && REQ_VALID[k]) begin
                w_found = 1'b1;
                GNT_IDX = ID_W'(k);
            end
        end
        if (w_found) GNT = NUM_REQ'(1) << GNT_IDX;
    end
`else
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;

    // Rotate so that bit 0 of w_rot is requester PTR; the first set bit is then the winner.
    assign w_dbl = {REQ_VALID, REQ_VALID} >> PTR;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        logic w_found;
        int   w_idx;
        GNT     = '0;
        GNT_IDX = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_idx   = int'(PTR) + k;
                if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
                GNT_IDX = ID_W'(w_idx);
            end
        end
        if (w_found) GNT = NUM_REQ'(1) << GNT_IDX;
    end
`endif

endmodule

// File: rtl/not_gate_arbiter.sv
// Shares one inverter among NUM_REQ requesters; registered response tagged with the winner's ID.
// Build macro NOT_ARB_FIXED_PRIO_EN selects fixed priority and removes the round-robin pointer.
module not_gate_arbiter
    import not_gate_arb_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]       REQ_READY,
    output logic                     RSP_VALID,
    output logic [WIDTH-1:0]         RSP_DATA,
    output logic [ID_W-1:0]          RSP_ID,
    input  logic                     RSP_READY
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;
    logic [ID_W-1:0]    w_ptr;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_can_accept;
    logic               w_accept;
    logic [WIDTH-1:0]   w_words [NUM_REQ];
    logic [WIDTH-1:0]   w_inv;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_words[g] = REQ_DATA[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .REQ_VALID (REQ_VALID),
        .PTR       (w_ptr),
        .GNT       (w_gnt),
        .GNT_IDX   (w_gnt_idx)
    );

    not_gate #(
        .WIDTH (WIDTH)
    ) u_not (
        .i_a (w_words[w_gnt_idx]),
        .o_y (w_inv)
    );

    // Ready depends only on state and downstream ready, never on RSP_VALID combinationally.
    assign w_can_accept = (r_state == ST_IDLE) | RSP_READY;
    assign REQ_READY    = RSTn ? (w_gnt & {NUM_REQ{w_can_accept}}) : '0;
    assign w_accept     = |REQ_READY;

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else if (w_accept) begin
            r_state    <= ST_HOLD;
            r_rsp_data <= w_inv;
            r_rsp_id   <= w_gnt_idx;
        end else if (r_state == ST_HOLD && RSP_READY) begin
            r_state    <= ST_IDLE;
        end
    end

`ifdef NOT_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [ID_W-1:0] r_ptr;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        end
    end

    assign w_ptr = r_ptr;
`endif

    assign RSP_VALID = (r_state == ST_HOLD);
    assign RSP_DATA  = r_rsp_data;
    assign RSP_ID    = r_rsp_id;

endmodule

// File: tb/tb_not_gate_arbiter.sv
// Scoreboard bench for not_gate_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_not_gate_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               id;
    } rsp_t;

    logic                     CLK = 1'b0;
    logic                     RSTn = 1'b0;
    logic [NUM_REQ-1:0]       REQ_VALID = '0;
    logic [NUM_REQ*WIDTH-1:0] REQ_DATA = '0;
    logic [NUM_REQ-1:0]       REQ_READY;
    logic                     RSP_VALID;
    logic [WIDTH-1:0]         RSP_DATA;
    logic [ID_W-1:0]          RSP_ID;
    logic                     RSP_READY = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    rsp_t exp_q[$];
    logic [WIDTH-1:0] last_data = '0;
    int   last_id = 0;
    int   model_ptr = 0;

    not_gate_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .REQ_VALID (REQ_VALID),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .RSP_ID    (RSP_ID),
        .RSP_READY (RSP_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides the grant and records the accepted result.
    task automatic cycle(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*WIDTH-1:0] d,
                         input logic rr, input logic rst_n);
        logic [NUM_REQ-1:0] exp_ready;
        int   start;
        int   win;
        bit   can;
        @(posedge CLK);
        #2;
        REQ_VALID = v;
        REQ_DATA  = d;
        RSP_READY = rr;
        RSTn      = rst_n;
        #1;
        exp_ready = '0;
        win = -1;
        if (rst_n) begin
            can = (exp_q.size() == 0) || rr;
`ifdef NOT_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = model_ptr;
`endif
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (start + k) % NUM_REQ;
                if (win < 0 && v[i]) win = i;
            end
            if (win >= 0 && can) exp_ready[win] = 1'b1;
            else win = -1;
        end
        check("req_ready", 64'(REQ_READY), 64'(exp_ready));
        @(negedge CLK);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            model_ptr = 0;
            last_data = '0;
            last_id   = 0;
        end else if (win >= 0) begin
            rsp_t r;
            r.data = ~d[win*WIDTH +: WIDTH];
            r.id   = win;
            exp_q.push_back(r);
            last_data = r.data;
            last_id   = win;
            model_ptr = (win + 1) % NUM_REQ;
        end
    endtask

    // Monitor: compares the held response every cycle and retires it on a handshake.
    always @(negedge CLK) begin
        if (mon_en) begin
            check("rsp_valid", 64'(RSP_VALID), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0 && RSP_VALID === 1'b1) begin
                check("rsp_data", 64'(RSP_DATA), 64'(exp_q[0].data));
                check("rsp_id", 64'(RSP_ID), 64'(exp_q[0].id));
                if (RSP_READY) void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                check("rsp_data_idle", 64'(RSP_DATA), 64'(last_data));
                check("rsp_id_idle", 64'(RSP_ID), 64'(last_id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_REQ*WIDTH-1:0] rot_words;
        rot_words = {8'hFF, 8'hF0, 8'h0F, 8'h00};

        // Reset with all requesters valid: no grant, outputs cleared.
        cycle(4'hF, rot_words, 1'b1, 1'b0);
        mon_en = 1'b1;
        cycle(4'hF, rot_words, 1'b1, 1'b0);

        // First grant after release goes to requester 0.
        cycle(4'hF, rot_words, 1'b1, 1'b1);
        cycle(4'h0, rot_words, 1'b1, 1'b1);

        // Single request on requester 2.
        cycle(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1, 1'b1);
        cycle(4'h0, '0, 1'b1, 1'b1);
        cycle(4'h0, '0, 1'b1, 1'b1);

        // Rotation from a fresh pointer.
        cycle(4'h0, '0, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) cycle(4'hF, rot_words, 1'b1, 1'b1);
        cycle(4'h0, '0, 1'b1, 1'b1);

        // Backpressure after a response from requester 1 carrying 8'h3C.
        cycle(4'h0, '0, 1'b1, 1'b0);
        cycle(4'b0010, {8'h11, 8'h22, 8'hC3, 8'h44}, 1'b1, 1'b1);
        for (int n = 0; n < 3; n++) cycle(4'hF, {8'h11, 8'h22, 8'hC3, 8'h44}, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) cycle(4'hF, {8'h11, 8'h22, 8'hC3, 8'h44}, 1'b1, 1'b1);

        // Reset while a response is held under backpressure.
        cycle(4'b1000, {8'h5A, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1);
        cycle(4'h0, '0, 1'b0, 1'b1);
        cycle(4'h0, '0, 1'b0, 1'b0);
        cycle(4'hF, rot_words, 1'b1, 1'b1);
        cycle(4'h0, '0, 1'b1, 1'b1);

        // Two requesters held valid: alternates under round-robin, requester 1 only under fixed priority.
        for (int n = 0; n < 6; n++) cycle(4'b1010, {8'h77, 8'h00, 8'h99, 8'h00}, 1'b1, 1'b1);

        // Randomized traffic with occasional backpressure and rare resets.
        for (int n = 0; n < 600; n++) begin
            logic [NUM_REQ-1:0] v;
            logic               rr;
            logic               rs;
            v  = NUM_REQ'($urandom);
            rr = ($urandom_range(0, 9) < 7);
            rs = ($urandom_range(0, 99) != 0);
            cycle(v, ($urandom), rr, rs);
        end

        for (int n = 0; n < 3; n++) cycle(4'h0, '0, 1'b1, 1'b1);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
